// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer request/response bundle
interface fetch_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                c_i_start;
  logic                c_i_halt;
  logic                c_i_stall;
  logic                c_i_exc_valid;
  logic                c_i_br_valid;
  logic [PC_WIDTH-1:0] c_i_br_target;
  logic                c_i_jmp_valid;
  logic [PC_WIDTH-1:0] c_i_jmp_target;
  logic                c_o_fetch_ce;
  logic                c_o_change_pc;
  logic [PC_WIDTH-1:0] c_o_pc;
  logic                c_o_flush;
  logic [2:0]          c_o_state;
  logic [15:0]         c_o_redirect_cnt;

  // master: hazard/branch side driving requests; slave: the sequencer
  modport master (
    output c_i_start, c_i_halt, c_i_stall, c_i_exc_valid,
           c_i_br_valid, c_i_br_target, c_i_jmp_valid, c_i_jmp_target,
    input  c_o_fetch_ce, c_o_change_pc, c_o_pc, c_o_flush, c_o_state, c_o_redirect_cnt
  );

  modport slave (
    input  c_i_start, c_i_halt, c_i_stall, c_i_exc_valid,
           c_i_br_valid, c_i_br_target, c_i_jmp_valid, c_i_jmp_target,
    output c_o_fetch_ce, c_o_change_pc, c_o_pc, c_o_flush, c_o_state, c_o_redirect_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage redirect arbitration, stall hold and flush sequencing
module fetch_sequencer #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic          c_clk,
  input  logic          c_rst,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  state_t              state;
  logic                fetch_ce, change_pc, flush;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         redirect_cnt;
  logic [3:0]          flush_cnt;
  logic                pend_valid, pend_is_br;
  logic [PC_WIDTH-1:0] pend_target;

  logic                cur_valid, cur_is_br;
  logic [PC_WIDTH-1:0] cur_target;
  logic                merged_valid, merged_is_br;
  logic [PC_WIDTH-1:0] merged_target;
  logic                go_halt, go_start, redir_fire;
  logic [PC_WIDTH-1:0] redir_pc;

  always_comb begin
    cur_valid  = bus.c_i_br_valid | bus.c_i_jmp_valid;
    cur_is_br  = bus.c_i_br_valid;
    cur_target = bus.c_i_br_valid ? bus.c_i_br_target : bus.c_i_jmp_target;

    // a jump may not displace a held branch; equal or higher priority overwrites
    if (cur_valid && (cur_is_br || !(pend_valid && pend_is_br))) begin
      merged_valid  = 1'b1;
      merged_is_br  = cur_is_br;
      merged_target = cur_target;
    end else begin
      merged_valid  = pend_valid;
      merged_is_br  = pend_is_br;
      merged_target = pend_target;
    end

    go_halt  = bus.c_i_halt && (state != ST_IDLE);
    go_start = ((state == ST_IDLE) || (state == ST_HALT)) && bus.c_i_start && !bus.c_i_halt;

    redir_fire = 1'b0;
    redir_pc   = cur_target;
    if ((state == ST_RUN) || (state == ST_FLUSH)) begin
      redir_fire = bus.c_i_exc_valid | cur_valid;
      redir_pc   = bus.c_i_exc_valid ? EXC_VECTOR : cur_target;
    end else if (state == ST_STALL) begin
      redir_fire = bus.c_i_exc_valid | (!bus.c_i_stall && merged_valid);
      redir_pc   = bus.c_i_exc_valid ? EXC_VECTOR : merged_target;
    end
  end

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state        <= ST_IDLE;
      fetch_ce     <= 1'b0;
      change_pc    <= 1'b0;
      flush        <= 1'b0;
      pc           <= RESET_PC;
      redirect_cnt <= '0;
      flush_cnt    <= '0;
      pend_valid   <= 1'b0;
      pend_is_br   <= 1'b0;
      pend_target  <= '0;
    end else begin
      change_pc <= 1'b0;
      if (go_halt) begin
        state      <= ST_HALT;
        fetch_ce   <= 1'b0;
        flush      <= 1'b0;
        flush_cnt  <= '0;
        pend_valid <= 1'b0;
        pend_is_br <= 1'b0;
      end else if (go_start) begin
        state     <= ST_RUN;
        fetch_ce  <= 1'b1;
        change_pc <= 1'b1;
        flush     <= 1'b0;
        pc        <= RESET_PC & ALIGN_MASK;
      end else if (redir_fire) begin
        state      <= ST_FLUSH;
        fetch_ce   <= 1'b1;
        change_pc  <= 1'b1;
        flush      <= 1'b1;
        pc         <= redir_pc & ALIGN_MASK;
        flush_cnt  <= FLUSH_LOAD;
        pend_valid <= 1'b0;
        pend_is_br <= 1'b0;
        if (redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
      end else begin
        case (state)
          ST_RUN: begin
            if (bus.c_i_stall) begin
              state    <= ST_STALL;
              fetch_ce <= 1'b0;
            end
          end
          ST_FLUSH: begin
            // stall seen here is left for the first RUN cycle to act on
            if (flush_cnt != 4'd0) begin
              flush_cnt <= flush_cnt - 4'd1;
            end else begin
              flush <= 1'b0;
              state <= ST_RUN;
            end
          end
          ST_STALL: begin
            if (bus.c_i_stall) begin
              pend_valid  <= merged_valid;
              pend_is_br  <= merged_is_br;
              pend_target <= merged_target;
            end else begin
              state    <= ST_RUN;
              fetch_ce <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.c_o_state        = state;
  assign bus.c_o_fetch_ce     = fetch_ce;
  assign bus.c_o_change_pc    = change_pc;
  assign bus.c_o_flush        = flush;
  assign bus.c_o_pc           = pc;
  assign bus.c_o_redirect_cnt = redirect_cnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
  localparam logic [6:0] C_NONE = 7'h00, C_RST = 7'h40, C_START = 7'h20, C_HALT = 7'h10,
                         C_STALL = 7'h08, C_EXC = 7'h04, C_BR = 7'h02, C_JMP = 7'h01;
  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STALL = 3'd2, S_FLUSH = 3'd3, S_HALT = 3'd4;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [53:0] exp;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [53:0] sb[$];
  logic [53:0] exp_v;

  fetch_sequencer_if #(.PC_WIDTH(32)) bus ();

  fetch_sequencer dut (
    .c_clk (clk),
    .c_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(input logic [6:0] ctl, input logic [31:0] bt, input logic [31:0] jt,
                               input logic [2:0] st, input logic ce, input logic cpc, input logic fl,
                               input logic [31:0] pc, input logic [15:0] cnt);
    step_t r;
    r.ctl = ctl;
    r.bt  = bt;
    r.jt  = jt;
    r.exp = {st, ce, cpc, fl, pc, cnt};
    return r;
  endfunction

  function automatic logic [53:0] observed();
    return {bus.c_o_state, bus.c_o_fetch_ce, bus.c_o_change_pc, bus.c_o_flush,
            bus.c_o_pc, bus.c_o_redirect_cnt};
  endfunction

  task automatic drive(input step_t s);
    rst                = s.ctl[6];
    bus.c_i_start      = s.ctl[5];
    bus.c_i_halt       = s.ctl[4];
    bus.c_i_stall      = s.ctl[3];
    bus.c_i_exc_valid  = s.ctl[2];
    bus.c_i_br_valid   = s.ctl[1];
    bus.c_i_jmp_valid  = s.ctl[0];
    bus.c_i_br_target  = s.bt;
    bus.c_i_jmp_target = s.jt;
  endtask

  task automatic test_reset();
    step_t s[$];
    s.push_back(mk(C_RST,  0, 0, S_IDLE, 0, 0, 0, 0, 0));
    s.push_back(mk(C_NONE, 0, 0, S_IDLE, 0, 0, 0, 0, 0));
    s.push_back(mk(C_BR,   32'h44, 0, S_IDLE, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL reset[%0d]: got {st,ce,cpc,fl,pc,cnt}=%h want %h", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_start();
    step_t s[$];
    s.push_back(mk(C_RST,   0, 0, S_IDLE, 0, 0, 0, 0, 0));
    s.push_back(mk(C_START, 0, 0, S_RUN,  1, 1, 0, 0, 0));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,  1, 0, 0, 0, 0));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,  1, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL start[%0d]: got {st,ce,cpc,fl,pc,cnt}=%h want %h", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_branch();
    step_t s[$];
    s.push_back(mk(C_RST,   0, 0, S_IDLE,  0, 0, 0, 0, 0));
    s.push_back(mk(C_START, 0, 0, S_RUN,   1, 1, 0, 0, 0));
    s.push_back(mk(C_BR,    32'h42, 0, S_FLUSH, 1, 1, 1, 32'h40, 1));
    s.push_back(mk(C_NONE,  0, 0, S_FLUSH, 1, 0, 1, 32'h40, 1));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h40, 1));
    s.push_back(mk(C_JMP,   0, 32'h1237, S_FLUSH, 1, 1, 1, 32'h1234, 2));
    s.push_back(mk(C_NONE,  0, 0, S_FLUSH, 1, 0, 1, 32'h1234, 2));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h1234, 2));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL branch[%0d]: got {st,ce,cpc,fl,pc,cnt}=%h want %h", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_priority();
    step_t s[$];
    s.push_back(mk(C_RST,   0, 0, S_IDLE,  0, 0, 0, 0, 0));
    s.push_back(mk(C_START, 0, 0, S_RUN,   1, 1, 0, 0, 0));
    s.push_back(mk(C_EXC | C_BR | C_JMP | C_STALL, 32'h200, 32'h300, S_FLUSH, 1, 1, 1, 32'h80, 1));
    s.push_back(mk(C_NONE,  0, 0, S_FLUSH, 1, 0, 1, 32'h80, 1));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h80, 1));
    s.push_back(mk(C_BR | C_JMP, 32'h500, 32'h600, S_FLUSH, 1, 1, 1, 32'h500, 2));
    s.push_back(mk(C_NONE,  0, 0, S_FLUSH, 1, 0, 1, 32'h500, 2));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h500, 2));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL priority[%0d]: got {st,ce,cpc,fl,pc,cnt}=%h want %h", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_stall_pending();
    step_t s[$];
    s.push_back(mk(C_RST,   0, 0, S_IDLE,  0, 0, 0, 0, 0));
    s.push_back(mk(C_START, 0, 0, S_RUN,   1, 1, 0, 0, 0));
    s.push_back(mk(C_STALL, 0, 0, S_STALL, 0, 0, 0, 0, 0));
    s.push_back(mk(C_STALL | C_JMP, 0, 32'h100, S_STALL, 0, 0, 0, 0, 0));
    s.push_back(mk(C_STALL | C_BR, 32'h200, 0, S_STALL, 0, 0, 0, 0, 0));
    s.push_back(mk(C_STALL, 0, 0, S_STALL, 0, 0, 0, 0, 0));
    s.push_back(mk(C_NONE,  0, 0, S_FLUSH, 1, 1, 1, 32'h200, 1));
    s.push_back(mk(C_NONE,  0, 0, S_FLUSH, 1, 0, 1, 32'h200, 1));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h200, 1));
    s.push_back(mk(C_STALL, 0, 0, S_STALL, 0, 0, 0, 32'h200, 1));
    s.push_back(mk(C_STALL | C_BR, 32'h300, 0, S_STALL, 0, 0, 0, 32'h200, 1));
    s.push_back(mk(C_STALL | C_JMP, 0, 32'h400, S_STALL, 0, 0, 0, 32'h200, 1));
    s.push_back(mk(C_NONE,  0, 0, S_FLUSH, 1, 1, 1, 32'h300, 2));
    s.push_back(mk(C_NONE,  0, 0, S_FLUSH, 1, 0, 1, 32'h300, 2));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h300, 2));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h300, 2));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL stall_pending[%0d]: got {st,ce,cpc,fl,pc,cnt}=%h want %h", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_exc_in_stall();
    step_t s[$];
    s.push_back(mk(C_RST,   0, 0, S_IDLE,  0, 0, 0, 0, 0));
    s.push_back(mk(C_START, 0, 0, S_RUN,   1, 1, 0, 0, 0));
    s.push_back(mk(C_STALL, 0, 0, S_STALL, 0, 0, 0, 0, 0));
    s.push_back(mk(C_STALL | C_BR, 32'h200, 0, S_STALL, 0, 0, 0, 0, 0));
    s.push_back(mk(C_STALL | C_EXC, 0, 0, S_FLUSH, 1, 1, 1, 32'h80, 1));
    s.push_back(mk(C_NONE,  0, 0, S_FLUSH, 1, 0, 1, 32'h80, 1));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h80, 1));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h80, 1));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL exc_in_stall[%0d]: got {st,ce,cpc,fl,pc,cnt}=%h want %h", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    s.push_back(mk(C_RST,   0, 0, S_IDLE,  0, 0, 0, 0, 0));
    s.push_back(mk(C_START, 0, 0, S_RUN,   1, 1, 0, 0, 0));
    s.push_back(mk(C_BR,    32'h10, 0, S_FLUSH, 1, 1, 1, 32'h10, 1));
    s.push_back(mk(C_BR,    32'h44, 0, S_FLUSH, 1, 1, 1, 32'h44, 2));
    s.push_back(mk(C_STALL, 0, 0, S_FLUSH, 1, 0, 1, 32'h44, 2));
    s.push_back(mk(C_STALL, 0, 0, S_RUN,   1, 0, 0, 32'h44, 2));
    s.push_back(mk(C_STALL, 0, 0, S_STALL, 0, 0, 0, 32'h44, 2));
    s.push_back(mk(C_NONE,  0, 0, S_RUN,   1, 0, 0, 32'h44, 2));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got {st,ce,cpc,fl,pc,cnt}=%h want %h", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_halt_reset();
    step_t s[$];
    s.push_back(mk(C_RST,   0, 0, S_IDLE,  0, 0, 0, 0, 0));
    s.push_back(mk(C_START, 0, 0, S_RUN,   1, 1, 0, 0, 0));
    s.push_back(mk(C_BR,    32'h40, 0, S_FLUSH, 1, 1, 1, 32'h40, 1));
    s.push_back(mk(C_HALT,  0, 0, S_HALT,  0, 0, 0, 32'h40, 1));
    s.push_back(mk(C_START | C_HALT, 0, 0, S_HALT, 0, 0, 0, 32'h40, 1));
    s.push_back(mk(C_NONE,  0, 0, S_HALT,  0, 0, 0, 32'h40, 1));
    s.push_back(mk(C_START, 0, 0, S_RUN,   1, 1, 0, 0, 1));
    s.push_back(mk(C_BR,    32'h44, 0, S_FLUSH, 1, 1, 1, 32'h44, 2));
    s.push_back(mk(C_RST | C_BR, 32'h88, 0, S_IDLE, 0, 0, 0, 0, 0));
    s.push_back(mk(C_NONE,  0, 0, S_IDLE,  0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL halt_reset[%0d]: got {st,ce,cpc,fl,pc,cnt}=%h want %h", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_saturation();
    step_t s[$];
    s.push_back(mk(C_RST,   0, 0, S_IDLE,  0, 0, 0, 0, 0));
    s.push_back(mk(C_START, 0, 0, S_RUN,   1, 1, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
    end
    drive(mk(C_BR, 32'h8, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 65536; n++) @(posedge clk);
    #1;
    sb.push_back(mk(C_BR, 32'h8, 0, S_FLUSH, 1, 1, 1, 32'h8, 16'hFFFF).exp);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (observed() !== exp_v) begin
      errors++;
      $display("FAIL saturation: got {st,ce,cpc,fl,pc,cnt}=%h want %h", observed(), exp_v);
    end
  endtask

  initial begin
    drive(mk(C_RST, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_start();
    test_branch();
    test_priority();
    test_stall_pending();
    test_exc_in_stall();
    test_back_to_back();
    test_halt_reset();
    test_saturation();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
